hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. It produces the bubble-select signal consumed by the ID-stage control mux (1 = pass decoded control, 0 = zero all control), plus the PC and IF/ID write enables and the IF/ID flush. It sits in the ID stage. It compares ID source registers against in-flight EX and MEM destinations. Multi-cycle stalls are sequenced by a small state machine, and stall and flush events are counted for the debug unit.

## Interface
- Parameters:
- `NB_REG`, default 5, register-index width.
- `NB_CNT`, default 32, performance-counter width.
- Ports:
- `i_clk`  in  1  core clock
- `i_reset`  in  1  asynchronous, active-low reset
- `is_enable`  in  1  debug-unit run/step enable; 0 freezes the pipeline
- `is_id_rs`  in  NB_REG  rs of the instruction in ID
- `is_id_rt`  in  NB_REG  rt of the instruction in ID
- `is_id_uses_rt`  in  1  ID instruction reads rt (R-type, store, beq/bne)
- `is_id_branch`  in  1  ID instruction is beq/bne (compared in ID)
- `is_id_jump_taken`  in  1  branch taken or jump resolved in ID
- `is_id_halt`  in  1  HALT opcode in ID
- `is_idex_MemRead`  in  1  EX-stage instruction is a load
- `is_idex_RegWrite`  in  1  EX-stage instruction writes a register
- `is_idex_wreg`  in  NB_REG  EX-stage destination register
- `is_exmem_MemRead`  in  1  MEM-stage instruction is a load
- `is_exmem_wreg`  in  NB_REG  MEM-stage destination register
- `os_ctrl_select`  out  1  control-mux selector; 0 inserts a bubble
- `os_pc_write`  out  1  PC write enable
- `os_ifid_write`  out  1  IF/ID write enable
- `os_ifid_flush`  out  1  clears IF/ID on the next edge
- `os_halted`  out  1  pipeline halted
- `os_stall_count`  out  NB_CNT  bubble cycles inserted, saturating
- `os_flush_count`  out  NB_CNT  flushes issued, saturating

## Operation
- Definitions:
- `match(r)` = (r != 0) && (r == is_id_rs || (is_id_uses_rt && r == is_id_rt)).
- Register 0 never causes a hazard.
- Hazard classes, evaluated combinationally in RUN:
- H2 (2 bubbles): is_id_branch && is_idex_MemRead && match(is_idex_wreg).
- H1 (1 bubble), any of the following:
- is_idex_MemRead && match(is_idex_wreg) and not H2 (load-use).
- is_id_branch && is_idex_RegWrite && !is_idex_MemRead && match(is_idex_wreg).
- is_id_branch && is_exmem_MemRead && match(is_exmem_wreg).
- States:
- RUN:
- If is_id_halt, go to HALT.
- Else if H2, stall this cycle and go to STALL2.
- Else if H1, stall this cycle and stay in RUN; the hazard re-evaluates and clears naturally.
- Else pass.
- STALL2: stall unconditionally, then go to RUN.
- HALT: os_halted=1, all write enables 0, select 0, flush 0. Only reset exits.
- A stall cycle drives os_ctrl_select=0, os_pc_write=0, os_ifid_write=0, os_ifid_flush=0, and increments os_stall_count.
- Pass cycle: os_ctrl_select=1, os_pc_write=1, os_ifid_write=1, os_ifid_flush=is_id_jump_taken.
- os_flush_count increments on every pass cycle with a flush.
- Priority: halt > stall > flush. A taken branch with a pending hazard is not flushed until its stall completes.
- is_enable=0:
- All write enables 0, select 0, flush 0.
- State, counters and os_halted hold.
- No transitions occur.
- Counters saturate at 2^NB_CNT-1.

## Timing
- Hazard outputs are combinational from inputs and state; there is zero-cycle latency from hazard visibility to stall assertion.
- State and counters update on the i_clk rising edge, qualified by is_enable.
- Reset (i_reset=0, asynchronous):
- state=RUN, os_halted=0, both counters=0.
- While reset is asserted, os_ctrl_select, os_pc_write, os_ifid_write and os_ifid_flush are forced to 0.
- Reset mid-STALL2 returns to RUN immediately. The remaining bubble is dropped.
- After reset release, the first edge with no hazard advances the PC.
- H2 stalls exactly 2 consecutive enabled cycles regardless of inputs during the second cycle.
- H1 stalls while the condition holds; in a correct pipeline this is 1 cycle.

## Test plan
- Load-use hazard:
- Stimulus: is_idex_MemRead=1, is_idex_wreg=8, is_id_rs=8.
- Response: one stall cycle with select/pc_write/ifid_write=0, then pass once the load moves to MEM; os_stall_count=1.
- rt not read:
- Stimulus: is_idex_MemRead=1, is_idex_wreg=9, is_id_rt=9, is_id_uses_rt=0.
- Response: no stall; select=1.
- Load-to-branch:
- Stimulus: is_id_branch=1, is_idex_MemRead=1, wreg=4, rs=4.
- Response: exactly 2 stall cycles (RUN→STALL2→RUN); os_stall_count=2.
- Same instruction, branch taken: os_ifid_flush=1 only on the first pass cycle; os_flush_count=1.
- Register 0:
- Stimulus: is_idex_MemRead=1, is_idex_wreg=0, is_id_rs=0.
- Response: no stall.
- Halt:
- Stimulus: is_id_halt=1.
- Response: os_halted=1 after the edge; all enables 0 indefinitely until i_reset=0.
- Freeze and reset:
- Stimulus: is_enable=0 during STALL2.
- Response: state and counters hold, outputs 0; after re-enable, one more stall cycle occurs.
- Asserting i_reset=0 in STALL2 clears state and counters asynchronously.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard detector and stall sequencer for the 5-stage MIPS core.
// Drives bubble select, PC/IF-ID write enables and IF/ID flush, and counts stall and flush events.
module hazard_stall_ctrl #(
    parameter int NB_REG = 5,
    parameter int NB_CNT = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              is_enable,
    input  logic [NB_REG-1:0] is_id_rs,
    input  logic [NB_REG-1:0] is_id_rt,
    input  logic              is_id_uses_rt,
    input  logic              is_id_branch,
    input  logic              is_id_jump_taken,
    input  logic              is_id_halt,
    input  logic              is_idex_MemRead,
    input  logic              is_idex_RegWrite,
    input  logic [NB_REG-1:0] is_idex_wreg,
    input  logic              is_exmem_MemRead,
    input  logic [NB_REG-1:0] is_exmem_wreg,
    output logic              os_ctrl_select,
    output logic              os_pc_write,
    output logic              os_ifid_write,
    output logic              os_ifid_flush,
    output logic              os_halted,
    output logic [NB_CNT-1:0] os_stall_count,
    output logic [NB_CNT-1:0] os_flush_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL2 = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [NB_CNT-1:0] stall_count_r;
    logic [NB_CNT-1:0] flush_count_r;
    logic              h2_s;
    logic              h1_s;
    logic              stall_ev_s;
    logic              flush_ev_s;

    // Register 0 is hard-wired zero, so it can never be a true dependency.
    function automatic logic reg_match(input logic [NB_REG-1:0] r,
                                       input logic [NB_REG-1:0] rs,
                                       input logic [NB_REG-1:0] rt,
                                       input logic              uses_rt);
        return (r != {NB_REG{1'b0}}) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
        return (v == {NB_CNT{1'b1}}) ? v : v + {{(NB_CNT-1){1'b0}}, 1'b1};
    endfunction

    // Hazard classification from the ID sources against in-flight EX/MEM destinations.
    always_comb begin
        logic ex_hit_s;
        logic mem_hit_s;
        ex_hit_s  = reg_match(is_idex_wreg, is_id_rs, is_id_rt, is_id_uses_rt);
        mem_hit_s = reg_match(is_exmem_wreg, is_id_rs, is_id_rt, is_id_uses_rt);
        h2_s = is_id_branch && is_idex_MemRead && ex_hit_s;
        h1_s = (is_idex_MemRead && ex_hit_s && !h2_s)
            || (is_id_branch && is_idex_RegWrite && !is_idex_MemRead && ex_hit_s)
            || (is_id_branch && is_exmem_MemRead && mem_hit_s);
    end

    // Next-state and pipeline-control outputs; everything defaults to frozen.
    always_comb begin
        state_next_s   = state_r;
        os_ctrl_select = 1'b0;
        os_pc_write    = 1'b0;
        os_ifid_write  = 1'b0;
        os_ifid_flush  = 1'b0;
        stall_ev_s     = 1'b0;
        flush_ev_s     = 1'b0;
        if (!i_reset) begin
            state_next_s = ST_RUN;
        end else if (!is_enable) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                ST_RUN: begin
                    // A halting instruction neither advances nor counts as a bubble.
                    if (is_id_halt) begin
                        state_next_s = ST_HALT;
                    end else if (h2_s) begin
                        stall_ev_s   = 1'b1;
                        state_next_s = ST_STALL2;
                    end else if (h1_s) begin
                        stall_ev_s   = 1'b1;
                    end else begin
                        os_ctrl_select = 1'b1;
                        os_pc_write    = 1'b1;
                        os_ifid_write  = 1'b1;
                        os_ifid_flush  = is_id_jump_taken;
                        flush_ev_s     = is_id_jump_taken;
                    end
                end
                ST_STALL2: begin
                    stall_ev_s   = 1'b1;
                    state_next_s = ST_RUN;
                end
                ST_HALT: begin
                    state_next_s = ST_HALT;
                end
                default: begin
                    state_next_s = ST_RUN;
                end
            endcase
        end
    end

    // State and saturating event counters, advanced only while enabled.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r       <= ST_RUN;
            stall_count_r <= {NB_CNT{1'b0}};
            flush_count_r <= {NB_CNT{1'b0}};
        end else if (is_enable) begin
            state_r <= state_next_s;
            if (stall_ev_s) begin
                stall_count_r <= sat_inc(stall_count_r);
            end
            if (flush_ev_s) begin
                flush_count_r <= sat_inc(flush_count_r);
            end
        end else begin
            state_r       <= state_r;
            stall_count_r <= stall_count_r;
            flush_count_r <= flush_count_r;
        end
    end

    assign os_halted      = (state_r == ST_HALT);
    assign os_stall_count = stall_count_r;
    assign os_flush_count = flush_count_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table, directed multi-cycle sequences,
// and randomized traffic against a bubble-budget reference model (4-bit counters to reach saturation).
module tb_hazard_stall_ctrl;

    localparam int CMAX = 15;

    logic       i_clk = 1'b0;
    logic       i_reset, is_enable;
    logic [4:0] is_id_rs, is_id_rt, is_idex_wreg, is_exmem_wreg;
    logic       is_id_uses_rt, is_id_branch, is_id_jump_taken, is_id_halt;
    logic       is_idex_MemRead, is_idex_RegWrite, is_exmem_MemRead;
    logic       os_ctrl_select, os_pc_write, os_ifid_write, os_ifid_flush, os_halted;
    logic [3:0] os_stall_count, os_flush_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: remaining bubbles owed, halted flag, counters.
    int m_bub;
    bit m_halted;
    int m_stall, m_flush;

    hazard_stall_ctrl #(.NB_REG(5), .NB_CNT(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .is_enable(is_enable),
        .is_id_rs(is_id_rs), .is_id_rt(is_id_rt), .is_id_uses_rt(is_id_uses_rt),
        .is_id_branch(is_id_branch), .is_id_jump_taken(is_id_jump_taken), .is_id_halt(is_id_halt),
        .is_idex_MemRead(is_idex_MemRead), .is_idex_RegWrite(is_idex_RegWrite),
        .is_idex_wreg(is_idex_wreg), .is_exmem_MemRead(is_exmem_MemRead),
        .is_exmem_wreg(is_exmem_wreg), .os_ctrl_select(os_ctrl_select),
        .os_pc_write(os_pc_write), .os_ifid_write(os_ifid_write), .os_ifid_flush(os_ifid_flush),
        .os_halted(os_halted), .os_stall_count(os_stall_count), .os_flush_count(os_flush_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string      name;
        logic       br, jt, uses_rt, ex_mr, ex_rw, mem_mr;
        logic [4:0] rs, rt, ex_wr, mem_wr;
        logic       exp_stall, exp_flush;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic br, logic jt, logic [4:0] rs, logic [4:0] rt,
                                logic urt, logic exmr, logic exrw, logic [4:0] exwr,
                                logic memmr, logic [4:0] memwr, logic st, logic fl);
        vec_t v;
        v.name = n; v.br = br; v.jt = jt; v.rs = rs; v.rt = rt; v.uses_rt = urt;
        v.ex_mr = exmr; v.ex_rw = exrw; v.ex_wr = exwr; v.mem_mr = memmr; v.mem_wr = memwr;
        v.exp_stall = st; v.exp_flush = fl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        is_enable = 1'b1; is_id_halt = 1'b0;
        is_id_branch = v.br; is_id_jump_taken = v.jt; is_id_rs = v.rs; is_id_rt = v.rt;
        is_id_uses_rt = v.uses_rt; is_idex_MemRead = v.ex_mr; is_idex_RegWrite = v.ex_rw;
        is_idex_wreg = v.ex_wr; is_exmem_MemRead = v.mem_mr; is_exmem_wreg = v.mem_wr;
    endtask

    task automatic drive_idle();
        drive_vec(mk("idle", 0, 0, 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 5'd0, 0, 0));
    endtask

    task automatic model_reset();
        m_bub = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    endtask

    function automatic bit reads(input logic [4:0] r);
        return (r != 5'd0) && (r == is_id_rs || (is_id_uses_rt && r == is_id_rt));
    endfunction

    // Bubbles the ID instruction owes given what is in flight ahead of it.
    function automatic int bubbles_needed();
        if (is_idex_MemRead && reads(is_idex_wreg)) return is_id_branch ? 2 : 1;
        if (is_id_branch && ((is_idex_RegWrite && reads(is_idex_wreg)) ||
                             (is_exmem_MemRead && reads(is_exmem_wreg)))) return 1;
        return 0;
    endfunction

    task automatic model_eval(output bit adv, output bit fl, output bit st, output bit fe,
                              output bit nh, output int nb);
        int need;
        adv = 0; fl = 0; st = 0; fe = 0; nh = m_halted; nb = m_bub;
        if (!i_reset || !is_enable || m_halted) begin
        end else if (m_bub > 0) begin
            st = 1; nb = m_bub - 1;
        end else if (is_id_halt) begin
            nh = 1;
        end else begin
            need = bubbles_needed();
            if (need > 0) begin
                st = 1; nb = need - 1;
            end else begin
                adv = 1; fl = is_id_jump_taken; fe = fl;
            end
        end
    endtask

    task automatic run_cycle(input string nm);
        bit adv, fl, st, fe, nh;
        int nb;
        #1;
        model_eval(adv, fl, st, fe, nh, nb);
        chk({nm, "/select"}, os_ctrl_select, adv);
        chk({nm, "/pc_write"}, os_pc_write, adv);
        chk({nm, "/ifid_write"}, os_ifid_write, adv);
        chk({nm, "/flush"}, os_ifid_flush, fl);
        chk({nm, "/halted"}, os_halted, m_halted);
        chk({nm, "/stall_count"}, os_stall_count, m_stall);
        chk({nm, "/flush_count"}, os_flush_count, m_flush);
        @(posedge i_clk);
        if (i_reset && is_enable) begin
            m_halted = nh; m_bub = nb;
            if (st && m_stall < CMAX) m_stall++;
            if (fe && m_flush < CMAX) m_flush++;
        end
        @(negedge i_clk);
    endtask

    initial begin
        vec_t v;
        model_reset();
        i_reset = 1'b0;
        drive_idle();
        @(negedge i_clk);
        run_cycle("reset_a");
        run_cycle("reset_b");
        i_reset = 1'b1;
        run_cycle("first_pass");

        //             name            br jt rs    rt    urt exmr exrw exwr  memmr memwr st fl
        vecs.push_back(mk("no_hazard",  0, 0, 5'd1, 5'd2, 1, 0, 0, 5'd3, 0, 5'd3, 0, 0));
        vecs.push_back(mk("load_use",   0, 0, 5'd8, 5'd2, 1, 1, 1, 5'd8, 0, 5'd0, 1, 0));
        vecs.push_back(mk("rt_unread",  0, 0, 5'd3, 5'd9, 0, 1, 1, 5'd9, 0, 5'd0, 0, 0));
        vecs.push_back(mk("rt_read",    0, 0, 5'd3, 5'd9, 1, 1, 1, 5'd9, 0, 5'd0, 1, 0));
        vecs.push_back(mk("reg0",       0, 0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 5'd0, 0, 0));
        vecs.push_back(mk("br_alu_ex",  1, 0, 5'd5, 5'd2, 1, 0, 1, 5'd5, 0, 5'd0, 1, 0));
        vecs.push_back(mk("alu_ex_fwd", 0, 0, 5'd5, 5'd2, 1, 0, 1, 5'd5, 0, 5'd0, 0, 0));
        vecs.push_back(mk("br_ld_mem",  1, 0, 5'd1, 5'd6, 1, 0, 0, 5'd0, 1, 5'd6, 1, 0));
        vecs.push_back(mk("ld_mem_fwd", 0, 0, 5'd1, 5'd6, 1, 0, 0, 5'd0, 1, 5'd6, 0, 0));
        vecs.push_back(mk("jump_taken", 0, 1, 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 5'd0, 0, 1));
        vecs.push_back(mk("br_ld_ex_t", 1, 1, 5'd4, 5'd2, 1, 1, 1, 5'd4, 0, 5'd0, 1, 0));
        vecs.push_back(mk("br_ld_ex",   1, 0, 5'd4, 5'd2, 1, 1, 1, 5'd4, 0, 5'd0, 1, 0));

        foreach (vecs[i]) begin
            v = vecs[i];
            drive_vec(v);
            #1;
            chk({v.name, "/tbl_select"}, os_ctrl_select, !v.exp_stall);
            chk({v.name, "/tbl_pc_write"}, os_pc_write, !v.exp_stall);
            chk({v.name, "/tbl_flush"}, os_ifid_flush, v.exp_flush);
            run_cycle(v.name);
            drive_idle();
            run_cycle({v.name, "_after1"});
            run_cycle({v.name, "_after2"});
        end

        // Taken load-to-branch: two bubbles, then one flushing pass; freeze mid-STALL2.
        drive_vec(mk("h2", 1, 1, 5'd4, 5'd2, 1, 1, 1, 5'd4, 0, 5'd0, 1, 0));
        run_cycle("h2_stall1");
        is_enable = 1'b0;
        run_cycle("freeze1");
        run_cycle("freeze2");
        chk("freeze_select", os_ctrl_select, 0);
        drive_vec(mk("h2b", 0, 1, 5'd7, 5'd7, 1, 0, 0, 5'd0, 0, 5'd0, 0, 1));
        is_id_halt = 1'b1;
        run_cycle("h2_stall2_ignores_inputs");
        is_id_halt = 1'b0;
        run_cycle("h2_flush_pass");
        is_id_jump_taken = 1'b0;
        run_cycle("h2_plain_pass");

        // Asynchronous reset in STALL2 drops the pending bubble.
        drive_vec(mk("h2r", 1, 0, 5'd4, 5'd2, 1, 1, 1, 5'd4, 0, 5'd0, 1, 0));
        run_cycle("h2r_stall1");
        drive_idle();
        #2 i_reset = 1'b0;
        model_reset();
        #1;
        chk("async_reset_stall_count", os_stall_count, 0);
        chk("async_reset_select", os_ctrl_select, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        run_cycle("post_reset_pass");

        // Halt sticks until reset, regardless of later inputs.
        is_id_halt = 1'b1;
        run_cycle("halt_enter");
        is_id_halt = 1'b0;
        is_id_jump_taken = 1'b1;
        run_cycle("halted1");
        chk("halted_flag", os_halted, 1);
        run_cycle("halted2");
        i_reset = 1'b0;
        model_reset();
        run_cycle("halt_reset");
        i_reset = 1'b1;

        for (int c = 0; c < 600; c++) begin
            i_reset          = ($urandom_range(0, 79) != 0);
            is_enable        = ($urandom_range(0, 7) != 0);
            is_id_halt       = ($urandom_range(0, 49) == 0);
            is_id_rs         = 5'($urandom_range(0, 3));
            is_id_rt         = 5'($urandom_range(0, 3));
            is_id_uses_rt    = 1'($urandom);
            is_id_branch     = 1'($urandom);
            is_id_jump_taken = 1'($urandom);
            is_idex_MemRead  = 1'($urandom);
            is_idex_RegWrite = 1'($urandom);
            is_idex_wreg     = 5'($urandom_range(0, 3));
            is_exmem_MemRead = 1'($urandom);
            is_exmem_wreg    = 5'($urandom_range(0, 3));
            if (!i_reset) model_reset();
            run_cycle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
